// File: rtl/gshare_predictor.sv
// Gshare global-history direction predictor: fetch-side table lookup, WB-side training.
// Optional speculative fetch history enabled by defining GSHARE_SPEC_HIST_EN.
module gshare_predictor #(
    parameter int unsigned HIST_BITS  = 8,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          if_pc,
    input  logic                 if_isbranch,
    output logic                 gl_pred_taken,
    output logic [HIST_BITS-1:0] if_ghr,
    output logic                 init_busy,
    input  logic                 wbisbranch,
    input  logic [15:0]          wb_pcplus2,
    input  logic [HIST_BITS-1:0] wb_ghr,
    input  logic                 wb_gl_pred,
    input  logic                 wb_taken,
    output logic                 gl_pred_correct
);

    localparam int unsigned ENTRIES = 1 << HIST_BITS;

    typedef enum logic {INIT, RUN} state_t;

    state_t               state;
    logic [HIST_BITS-1:0] sweep_cnt;
    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] ghr_fetch;
    logic [HIST_BITS-1:0] rd_idx;
    logic [HIST_BITS-1:0] wr_idx;
    logic [15:0]          wb_pc;
    logic [1:0]           cnt_tbl [ENTRIES];
    logic [1:0]           wr_cur;
    logic [1:0]           wr_next;
    logic                 train;

    // Init sweep FSM: one table entry per cycle, then RUN until the next reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + HIST_BITS'(1);
                    if (sweep_cnt == HIST_BITS'(ENTRIES - 1)) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    assign train = (state == RUN) & wbisbranch;

    // Fetch-side lookup; a same-cycle WB write is not forwarded
    assign rd_idx        = if_pc[HIST_BITS:1] ^ ghr_fetch;
    assign gl_pred_taken = (state == RUN) & cnt_tbl[rd_idx][1];
    assign if_ghr        = ghr_fetch;

    assign wb_pc  = wb_pcplus2 - 16'd2;
    assign wr_idx = wb_pc[HIST_BITS:1] ^ wb_ghr;
    assign wr_cur = cnt_tbl[wr_idx];

    // Saturating 2-bit counter update
    always_comb begin
        wr_next = wr_cur;
        if (wb_taken) begin
            if (wr_cur != 2'b11) wr_next = wr_cur + 2'b01;
        end else begin
            if (wr_cur != 2'b00) wr_next = wr_cur - 2'b01;
        end
    end

    // Counter storage is deliberately unreset; the sweep initialises it
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            cnt_tbl[sweep_cnt] <= INIT_STATE;
        end else if (train) begin
            cnt_tbl[wr_idx] <= wr_next;
        end
    end

    // Architectural history, shifted by resolved branches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr <= '0;
        end else if (train) begin
            ghr <= {ghr[HIST_BITS-2:0], wb_taken};
        end
    end

    assign gl_pred_correct = wbisbranch & (wb_gl_pred == wb_taken);

`ifdef GSHARE_SPEC_HIST_EN
    logic [HIST_BITS-1:0] spec_ghr;
    logic                 unused_bits;

    // Speculative history: shifted by predictions, repaired from WB on mispredict
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spec_ghr <= '0;
        end else if (state == RUN) begin
            if (wbisbranch && !gl_pred_correct) begin
                spec_ghr <= {wb_ghr[HIST_BITS-2:0], wb_taken};
            end else if (if_isbranch) begin
                spec_ghr <= {spec_ghr[HIST_BITS-2:0], gl_pred_taken};
            end
        end
    end

    assign ghr_fetch   = spec_ghr;
    assign unused_bits = ^{if_pc[15:HIST_BITS+1], if_pc[0],
                           wb_pc[15:HIST_BITS+1], wb_pc[0]};
`else
    logic unused_bits;

    assign ghr_fetch   = ghr;
    assign unused_bits = ^{if_isbranch, if_pc[15:HIST_BITS+1], if_pc[0],
                           wb_pc[15:HIST_BITS+1], wb_pc[0]};
`endif

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Global-history direction predictor for the lc3b pipeline; sits beside the local predictor, upstream of choice_predictor.
- Fetch side: forms `if_pc[8:1] XOR ghr` and reads a 2-bit counter table to produce the global taken prediction plus a history snapshot, both carried down the pipe.
- WB side: trains the counter, shifts the history register, and produces `gl_pred_correct` for choice_predictor.
- Counter table is initialised by an internal sweep FSM after reset.

Parameters:
- HIST_BITS, 8, width of global history register and of table index.
- INIT_STATE, 2'b01, counter value written by init sweep (weakly not-taken).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- if_pc  input  16  fetch PC (lc3b_word).
- if_isbranch  input  1  fetch-stage instruction is a conditional branch (used only with optional feature).
- gl_pred_taken  output  1  global prediction for if_pc.
- if_ghr  output  HIST_BITS  history snapshot used for this fetch; carried to WB.
- init_busy  output  1  table sweep in progress.
- wbisbranch  input  1  WB-stage instruction is a conditional branch.
- wb_pcplus2  input  16  WB PC + 2.
- wb_ghr  input  HIST_BITS  snapshot carried from fetch.
- wb_gl_pred  input  1  gl_pred_taken carried from fetch.
- wb_taken  input  1  resolved direction.
- gl_pred_correct  output  1  wb_gl_pred == wb_taken.

Behaviour:
- Reset (reset_n low, async):
  - ghr = 0, init FSM = INIT, sweep counter = 0, init_busy = 1.
  - Counter array is not reset.
- Init FSM, states INIT and RUN:
  - INIT: each clk writes INIT_STATE to entry[sweep counter], then the counter increments.
  - At counter = 2^HIST_BITS−1, the write occurs and the FSM goes to RUN the next cycle; init_busy falls with that transition.
  - Sweep takes 2^HIST_BITS cycles (256 at default).
- During INIT:
  - gl_pred_taken = 0.
  - WB training writes and ghr updates are dropped.
  - gl_pred_correct is still computed.
- Read path (combinational, 0 latency):
  - rd_idx = if_pc[HIST_BITS:1] XOR ghr_fetch.
  - gl_pred_taken = table[rd_idx][1].
  - if_ghr = ghr_fetch.
- Write path, in RUN when wbisbranch = 1:
  - wb_pc = wb_pcplus2 − 2 (16-bit, wraps).
  - wr_idx = wb_pc[HIST_BITS:1] XOR wb_ghr.
  - Counter saturates at 3 when taken and at 0 when not-taken; otherwise ±1.
  - Read-modify-write uses the current table value; it is written at the clk edge.
- Same-cycle read and write to the same index: the read returns the pre-update value (no bypass).
- History without the feature:
  - ghr_fetch = ghr.
  - On WB branch in RUN: ghr <= {ghr[HIST_BITS−2:0], wb_taken}.
- gl_pred_correct:
  - Combinational: (wb_gl_pred == wb_taken) & wbisbranch.
  - 0 when wbisbranch = 0; choice_predictor ignores it then.
- reset_n asserted mid-sweep or mid-run: immediate return to INIT, full re-sweep.

Optional Feature:
- Macro: GSHARE_SPEC_HIST_EN.
- Defined:
  - Adds a speculative history register spec_ghr; ghr_fetch = spec_ghr.
  - On if_isbranch in RUN: spec_ghr <= {spec_ghr[HIST_BITS−2:0], gl_pred_taken}.
  - On WB branch with gl_pred_correct = 0: spec_ghr <= {wb_ghr[HIST_BITS−2:0], wb_taken}. This repair has priority over a same-cycle fetch shift.
  - Non-speculative ghr updates as usual.
  - spec_ghr resets to 0.
- Undefined:
  - if_isbranch is ignored; only the WB-updated ghr exists.

Test Plan:
- Reset, then count cycles → init_busy high for exactly 256 clks. Afterwards, gl_pred_taken = 0 for any if_pc (all entries 01).
- In RUN, WB branch with wb_pcplus2=16'h3012, wb_ghr=0, wb_taken=1, twice → entry 0x08 = 3; ghr = 8'h03. With ghr forced back to 0 via reset-free sequence, fetch if_pc=16'h3010 → gl_pred_taken = 1.
- Four not-taken trainings on a counter at 3 → value 0; a fifth holds at 0 (saturation). Four taken from 0 → holds at 3.
- Same-cycle fetch and WB to the same index, counter 01 → 10 → gl_pred_taken = 0 that cycle and 1 the next.
- wb_gl_pred=1, wb_taken=0, wbisbranch=1 → gl_pred_correct = 0; with wbisbranch=0 → 0. Assert reset_n low mid-sweep at count 100 → init_busy stays high, sweep restarts at 0.
- (GSHARE_SPEC_HIST_EN) spec_ghr=8'h05, fetch branch predicted 1 → 8'h0B. Same cycle WB mispredict, wb_ghr=8'h02, wb_taken=1 → spec_ghr = 8'h05 (repair wins).
